seq_alu_chunked: RTL



---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_chunk_slice.sv | 32 +++
 rtl/seq_alu_chunked.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the chunked Y86-64 ALU: op codes, FSM states, CC bit positions.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_XOR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Condition-code vector layout; CF sits above the Y86 ZF/SF/OF triple.
  localparam int unsigned CC_OF = 0;
  localparam int unsigned CC_SF = 1;
  localparam int unsigned CC_ZF = 2;
  localparam int unsigned CC_CF = 3;
  localparam int unsigned CC_W  = 4;

  // ADD and SUB share the adder path; AND and XOR are bitwise.
  function automatic logic is_arith(input logic [1:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_chunk_slice.sv
// Combinational CHUNK-bit ALU slice; carry passes straight through on logical ops.
module alu_chunk_slice
  import alu_pkg::*;
#(
  parameter int unsigned CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b_eff,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic [CHUNK-1:0] res,
  output logic             cout
);

  logic [CHUNK:0] sum;

  // Adder with carry-in, then op select.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b_eff} + (CHUNK+1)'(cin);
    res  = sum[CHUNK-1:0];
    cout = cin;
    case (op)
      ALU_ADD, ALU_SUB: begin
        res  = sum[CHUNK-1:0];
        cout = sum[CHUNK];
      end
      ALU_AND: res = a & b_eff;
      default: res = a ^ b_eff;
    endcase
  end

endmodule

// File: rtl/seq_alu_chunked.sv
// Multi-cycle ALU: processes WIDTH-bit operands CHUNK bits per clock, flags on completion.
module seq_alu_chunked
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             cf
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  result_d;
  logic [1:0]        op_q, op_d;
  logic              carry_q, carry_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [CC_W-1:0]   cc_d;

  logic [CHUNK-1:0]  a_chunk, b_chunk, s_res;
  logic              s_cout;

  // Pick the operand chunks addressed by the chunk index.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  alu_chunk_slice #(.CHUNK(CHUNK)) u_slice (
    .a     (a_chunk),
    .b_eff (b_chunk),
    .cin   (carry_q),
    .op    (op_q),
    .res   (s_res),
    .cout  (s_cout)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result;
    cc_d        = '0;
    cc_d[CC_ZF] = zf;
    cc_d[CC_SF] = sf;
    cc_d[CC_OF] = of;
    cc_d[CC_CF] = cf;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = (op == ALU_SUB) ? ~b : b;
          op_d    = op;
          carry_d = (op == ALU_SUB);
          idx_d   = '0;
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        for (int unsigned i = 0; i < NCHUNK; i++) begin
          if (idx_q == IDXW'(i)) result_d[i*CHUNK +: CHUNK] = s_res;
        end
        carry_d = s_cout;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          idx_d       = '0;
          cc_d[CC_ZF] = ~|result_d;
          cc_d[CC_SF] = result_d[WIDTH-1];
          cc_d[CC_OF] = is_arith(op_q) && (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                        (result_d[WIDTH-1] != a_q[WIDTH-1]);
          case (op_q)
            ALU_ADD: cc_d[CC_CF] = s_cout;
            ALU_SUB: cc_d[CC_CF] = ~s_cout;
            default: cc_d[CC_CF] = 1'b0;
          endcase
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and registered handshake/flag outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= ALU_ADD;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      result    <= '0;
      zf        <= 1'b0;
      sf        <= 1'b0;
      of        <= 1'b0;
      cf        <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      carry_q   <= carry_d;
      idx_q     <= idx_d;
      result    <= result_d;
      zf        <= cc_d[CC_ZF];
      sf        <= cc_d[CC_SF];
      of        <= cc_d[CC_OF];
      cf        <= cc_d[CC_CF];
      in_ready  <= (state_d == ST_IDLE);
      out_valid <= (state_d == ST_DONE);
    end
  end

endmodule
